// File: rtl/seg_pkg.sv
// Shared types and constants for the elastic pipeline segment register.
package seg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } seg_state_t;

  localparam int DEF_CTRL_W = 3;
  localparam int DEF_DATA_W = 72;

  function automatic logic [1:0] max_count(int skid);
    return (skid != 0) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/seg_entry.sv
// One enable-gated control+payload register with synchronous clear.
module seg_entry #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 72
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              en,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q_ctrl <= '0;
      q_data <= '0;
    end else if (en) begin
      q_ctrl <= d_ctrl;
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/segment_elastic.sv
// Elastic pipeline segment: valid/ready stage register with stall,
// flush, bubble control gating and optional two-entry skid buffer.
module segment_elastic
  import seg_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  localparam logic [1:0] MAX_CNT = max_count(SKID);

  seg_state_t state, state_nx;

  logic              acc, con, full;
  logic              h_en;
  logic [CTRL_W-1:0] h_dc, h_qc;
  logic [DATA_W-1:0] h_dd, h_qd;

  assign count     = state;
  assign full      = (count == MAX_CNT);
  assign out_valid = (state != EMPTY);
  assign acc       = in_valid && in_ready;
  assign con       = out_valid && out_ready;

  // Bubbles must never carry live write enables downstream.
  assign out_ctrl  = out_valid ? h_qc : '0;
  assign out_data  = h_qd;

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nx;
  end

  seg_entry #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_head (
    .clk   (clk),
    .clear (reset),
    .en    (h_en),
    .d_ctrl(h_dc),
    .d_data(h_dd),
    .q_ctrl(h_qc),
    .q_data(h_qd)
  );

  generate
    if (SKID == 0) begin : g_single

      assign in_ready = !reset && (!full || out_ready);
      assign h_en     = acc && !flush;
      assign h_dc     = in_ctrl;
      assign h_dd     = in_data;

      always_comb begin
        state_nx = state;
        if (flush)    state_nx = EMPTY;
        else if (acc) state_nx = ONE;
        else if (con) state_nx = EMPTY;
      end

    end else begin : g_skid

      logic              s_en;
      logic [CTRL_W-1:0] s_qc;
      logic [DATA_W-1:0] s_qd;

      // Depends only on held state, so a stall reaches upstream one edge late.
      assign in_ready = !reset && !full;

      seg_entry #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W)
      ) u_skid (
        .clk   (clk),
        .clear (reset),
        .en    (s_en),
        .d_ctrl(in_ctrl),
        .d_data(in_data),
        .q_ctrl(s_qc),
        .q_data(s_qd)
      );

      always_comb begin
        state_nx = state;
        h_en     = 1'b0;
        s_en     = 1'b0;
        h_dc     = in_ctrl;
        h_dd     = in_data;
        if (flush) begin
          state_nx = EMPTY;
        end else begin
          unique case (state)
            EMPTY: begin
              if (acc) begin
                h_en     = 1'b1;
                state_nx = ONE;
              end
            end
            ONE: begin
              if (acc && con) begin
                h_en = 1'b1;
              end else if (acc) begin
                s_en     = 1'b1;
                state_nx = TWO;
              end else if (con) begin
                state_nx = EMPTY;
              end
            end
            TWO: begin
              if (con) begin
                h_en     = 1'b1;
                h_dc     = s_qc;
                h_dd     = s_qd;
                state_nx = ONE;
              end
            end
            default: state_nx = EMPTY;
          endcase
        end
      end

    end
  endgenerate

endmodule
